// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a raw pushbutton.
// Emits a registered level and one-cycle press/release strobes.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter bit          INVERT          = 1'b0
) (
  input  logic CK12,
  input  logic CLEAR,
  input  logic BTN,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE
);

  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    sync1_d   = BTN ^ INVERT;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync2_q != level_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sync2_q == level_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // change held long enough: accept it
          level_d   = sync2_q;
          press_d   = sync2_q;
          release_d = ~sync2_q;
          state_d   = ST_STABLE;
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  always_ff @(posedge CK12) begin
    if (CLEAR) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign BTN_LEVEL   = level_q;
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bounce,
// checked against a run-length reference model on three DUT configs.
module tb_button_debounce;

  localparam int N = 3;
  localparam int DC0 = 4;
  localparam int DC1 = 4;
  localparam int DC2 = 2;

  int dcs[N];
  bit invs[N];

  logic         CK12 = 1'b0;
  logic         CLEAR = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] lvl, prs, rls;

  always #5 CK12 = ~CK12;

  button_debounce #(.DEBOUNCE_CYCLES(DC0), .INVERT(1'b0)) u_d0 (
    .CK12(CK12), .CLEAR(CLEAR), .BTN(btn[0]),
    .BTN_LEVEL(lvl[0]), .BTN_PRESS(prs[0]), .BTN_RELEASE(rls[0])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DC1), .INVERT(1'b1)) u_d1 (
    .CK12(CK12), .CLEAR(CLEAR), .BTN(btn[1]),
    .BTN_LEVEL(lvl[1]), .BTN_PRESS(prs[1]), .BTN_RELEASE(rls[1])
  );
  button_debounce #(.DEBOUNCE_CYCLES(DC2), .INVERT(1'b0)) u_d2 (
    .CK12(CK12), .CLEAR(CLEAR), .BTN(btn[2]),
    .BTN_LEVEL(lvl[2]), .BTN_PRESS(prs[2]), .BTN_RELEASE(rls[2])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // model: history of conditioned inputs and resets, one entry per edge
  bit bh[N][$];
  bit ch[$];
  bit mlvl[N], mprs[N], mrls[N];
  int run[N];
  int npress[N], nrel[N];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (edge %0d)",
               tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    int e;
    bit s;
    e = edge_n;
    for (int i = 0; i < N; i++) begin
      mprs[i] = 1'b0;
      mrls[i] = 1'b0;
      if (ch[e]) begin
        mlvl[i] = 1'b0;
        run[i]  = 0;
      end else begin
        s = (e >= 2 && !ch[e-1] && !ch[e-2]) ? bh[i][e-2] : 1'b0;
        if (s != mlvl[i]) begin
          run[i]++;
          if (run[i] == dcs[i] + 1) begin
            mlvl[i] = s;
            mprs[i] = s;
            mrls[i] = !s;
            run[i]  = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] b, input logic clr);
    btn   = b;
    CLEAR = clr;
    ch.push_back(clr);
    for (int i = 0; i < N; i++) bh[i].push_back(b[i] ^ invs[i]);
    model_edge();
    @(posedge CK12);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("level%0d", i), lvl[i], mlvl[i]);
      chk($sformatf("press%0d", i), prs[i], mprs[i]);
      chk($sformatf("release%0d", i), rls[i], mrls[i]);
      npress[i] += int'(prs[i]);
      nrel[i]   += int'(rls[i]);
    end
    edge_n++;
  endtask

  // drive the same logical press state p to every instance
  task automatic stepp(input bit p, input logic clr);
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = p ^ invs[i];
    step(b, clr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, r0;
    logic [N-1:0] cur;
    bit bouncy;
    int len;

    dcs  = '{DC0, DC1, DC2};
    invs = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < N; i++) begin
      mlvl[i] = 0; run[i] = 0; npress[i] = 0; nrel[i] = 0;
    end

    // reset with button held, then fresh press after release of CLEAR
    for (int k = 1; k <= 3; k++) begin
      stepp(1'b1, 1'b1);
      chk("rst_level", lvl[0], 1'b0);
      chk("rst_press", prs[0], 1'b0);
    end
    for (int k = 1; k <= 10; k++) begin
      stepp(1'b1, 1'b0);
      if (k == 6) chk("rst_lvl_e6", lvl[0], 1'b0);
      if (k == 7) chk("rst_prs_e7", prs[0], 1'b1);
      if (k == 8) chk("rst_prs_e8", prs[0], 1'b0);
    end
    chk("rst_one_press", npress[0] == 1, 1'b1);

    // clean release then clean press/release
    for (int k = 1; k <= 12; k++) stepp(1'b0, 1'b0);
    p0 = npress[0]; r0 = nrel[0];
    for (int k = 1; k <= 20; k++) begin
      stepp(1'b1, 1'b0);
      if (k == 6) chk("clean_prs_e6", prs[0], 1'b0);
      if (k == 7) begin
        chk("clean_prs_e7", prs[0], 1'b1);
        chk("inv_prs_e7", prs[1], 1'b1);
        chk("inv_lvl_e7", lvl[1], 1'b1);
      end
    end
    for (int k = 1; k <= 12; k++) begin
      stepp(1'b0, 1'b0);
      if (k == 7) chk("clean_rel_e7", rls[0], 1'b1);
      if (k == 8) chk("clean_lvl_e8", lvl[0], 1'b0);
    end
    chk("clean_counts", (npress[0] - p0 == 1) && (nrel[0] - r0 == 1), 1'b1);

    // bounce 1,0,1,0,1 then hold
    p0 = npress[0]; r0 = nrel[0];
    stepp(1'b1, 1'b0); stepp(1'b0, 1'b0);
    stepp(1'b1, 1'b0); stepp(1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      stepp(1'b1, 1'b0);
      if (k == 7) chk("bounce_prs_e7", prs[0], 1'b1);
    end
    chk("bounce_one_press", npress[0] - p0 == 1, 1'b1);
    chk("bounce_no_rel", nrel[0] - r0 == 0, 1'b1);

    // glitch of 4 rejected, 5 accepted
    for (int k = 1; k <= 12; k++) stepp(1'b0, 1'b0);
    p0 = npress[0]; r0 = nrel[0];
    for (int k = 1; k <= 4; k++) stepp(1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) stepp(1'b0, 1'b0);
    chk("glitch4_no_press", npress[0] - p0 == 0, 1'b1);
    chk("glitch4_level", lvl[0], 1'b0);
    for (int k = 1; k <= 5; k++) stepp(1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) stepp(1'b0, 1'b0);
    chk("glitch5_press", npress[0] - p0 == 1, 1'b1);

    // CLEAR pulse mid-WAIT discards, full latency after
    p0 = npress[0];
    for (int k = 1; k <= 16; k++) begin
      stepp(1'b1, k == 5);
      if (k == 7) chk("midwait_no_prs_e7", prs[0], 1'b0);
      if (k == 11) chk("midwait_lvl_e11", lvl[0], 1'b0);
      if (k == 12) chk("midwait_prs_e12", prs[0], 1'b1);
    end
    chk("midwait_one_press", npress[0] - p0 == 1, 1'b1);

    // random bouncy/quiet segments, independent per instance
    cur = btn;
    for (int seg = 0; seg < 250; seg++) begin
      bouncy = $urandom_range(0, 1) == 1;
      len = bouncy ? $urandom_range(1, 8) : $urandom_range(1, 14);
      if (!bouncy) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 1) == 1) cur[i] = ~cur[i];
      end
      for (int k = 0; k < len; k++) begin
        if (bouncy) begin
          for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1) cur[i] = ~cur[i];
        end
        step(cur, $urandom_range(0, 59) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Synchronises and debounces a raw pushbutton input in the CK12 domain and emits a clean level plus single-cycle press and release strobes. It sits directly upstream of the LED counter and drives that counter's CLEAR input, with BTN_LEVEL wired to CLEAR. Contact bounce and metastability must never reach the counter.

## Interface

- DEBOUNCE_CYCLES, default 240000: consecutive stable synchronised samples required to accept a change (20 ms at 12 MHz); legal range 2 to 2^24-1.
- INVERT, default 0: when 1, BTN is active-low and is inverted before the synchroniser.
- CK12 input 1: system clock, 12 MHz. All logic is on the rising edge.
- CLEAR input 1: reset; synchronous, active-high.
- BTN input 1: raw pushbutton, asynchronous to CK12, may bounce.
- BTN_LEVEL output 1: debounced button state, 1 = pressed. Drives the counter CLEAR.
- BTN_PRESS output 1: one-cycle strobe on an accepted 0->1 change of BTN_LEVEL.
- BTN_RELEASE output 1: one-cycle strobe on an accepted 1->0 change of BTN_LEVEL.

## Operation

- **Input conditioning:** b = BTN ^ INVERT feeds a two-flop synchroniser, sync1 then sync2. Only sync2 is used downstream.
- **Counter:** cnt, width = clog2(DEBOUNCE_CYCLES), unsigned. It never wraps. Its maximum used value is DEBOUNCE_CYCLES-1.
- **FSM states:** STABLE and WAIT.
- **STABLE:**
  - sync2 == BTN_LEVEL: stay in STABLE, cnt = 0.
  - sync2 != BTN_LEVEL: go to WAIT, cnt = 0.
- **WAIT:**
  - sync2 == BTN_LEVEL (bounce back): return to STABLE, cnt = 0. No output change and no strobe.
  - sync2 != BTN_LEVEL and cnt < DEBOUNCE_CYCLES-1: cnt increments and the FSM stays in WAIT.
  - sync2 != BTN_LEVEL and cnt == DEBOUNCE_CYCLES-1: BTN_LEVEL toggles, the matching strobe (PRESS if the new level is 1, RELEASE if 0) asserts for exactly this one cycle, and the FSM goes to STABLE with cnt = 0.
- **Strobes:** BTN_PRESS and BTN_RELEASE are registered. They are never high together and never high on consecutive cycles.
- **Reset (CLEAR = 1):** sync1, sync2, BTN_LEVEL, BTN_PRESS and BTN_RELEASE all go to 0; the FSM goes to STABLE and cnt to 0.
  - CLEAR has priority over every other event, including a toggle due on the same edge.
  - Reset mid-WAIT discards the pending change.
  - After CLEAR deasserts, a button held pressed is accepted as a fresh press: full latency applies and a BTN_PRESS strobe is generated.

## Timing

- **Clock edges:** edge 1 is the first CK12 rising edge at which b is sampled at its new value, with b held constant thereafter. Each step lands on the following edge:
  - sync1 updates on edge 1.
  - sync2 updates on edge 2.
  - The FSM enters WAIT on edge 3.
- **Accept latency:** BTN_LEVEL and its strobe update on edge DEBOUNCE_CYCLES+3.
- **Minimum accepted pulse:** any b excursion whose sync2 image lasts fewer than DEBOUNCE_CYCLES+1 cycles is rejected completely.
- **Strobe width:** exactly one CK12 cycle, coincident with the first cycle BTN_LEVEL shows its new value.
- **Inputs:** no combinational path from any input to any output.
- **Outputs:** all registered.
- **Reset latency:** all outputs read 0 in the cycle after the first edge with CLEAR = 1.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and INVERT = 0 unless stated.

- **Reset:** hold CLEAR = 1 for 3 edges with BTN = 1 -> BTN_LEVEL, BTN_PRESS and BTN_RELEASE are 0 throughout; after CLEAR drops, BTN_LEVEL rises on the 7th edge and BTN_PRESS is high for one cycle.
- **Clean press and release:** BTN 0->1 held for 20 cycles, then 1->0 -> BTN_PRESS is high on edge 7 after the rise and BTN_RELEASE is high on edge 7 after the fall; each strobe is high for one cycle; BTN_LEVEL tracks.
- **Bounce rejection:** BTN toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> exactly one BTN_PRESS, at edge 7 counted from the final 0->1 sample; no BTN_RELEASE.
- **Glitch rejection:** BTN high for exactly 4 cycles (one short of the accepted minimum of 5) -> BTN_LEVEL stays 0 and no strobes occur. BTN high for 5 cycles -> BTN_PRESS occurs.
- **Reset mid-WAIT:** BTN rises, then CLEAR pulses one cycle at edge 5 -> no strobe at edge 7; the press is accepted with full latency counted from CLEAR deassertion.
- **INVERT = 1:** BTN idles at 1 and is driven to 0 -> BTN_LEVEL = 1 and BTN_PRESS is strobed on edge 7.
